// File: rtl/encoder8to3_pend.sv
// Pending-request 8-to-3 priority encoder with a present/acknowledge handshake.
// Optional sticky overflow detection is compiled in when ENC_OVF_EN is defined.
module encoder8to3_pend (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic ack,
  output logic c,
  output logic a,
  output logic b,
  output logic valid,
  output logic busy,
  output logic ovf
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] w_req;
  logic [7:0] w_set;
  logic [7:0] w_clr;
  logic [7:0] r_pend;
  logic [7:0] w_pend_nxt;
  logic [2:0] r_code;
  logic [2:0] w_code_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic       r_busy;

  // Highest set bit index; bit 7 has top priority.
  function automatic logic [2:0] f_highest(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign w_req = {d7, d6, d5, d4, d3, d2, d1, d0};

  // Next-state, dispatch and pending-register update; a new set beats an ack clear.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_valid_nxt = r_valid;
    w_clr       = 8'h00;
    if (en) begin
      w_set = w_req;
    end else begin
      w_set = 8'h00;
    end
    case (r_state)
      ST_IDLE: begin
        if (en && (r_pend != 8'h00)) begin
          w_state_nxt = ST_PRESENT;
          w_code_nxt  = f_highest(r_pend);
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          w_clr       = 8'h01 << r_code;
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_PRESENT;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    w_pend_nxt = (r_pend & ~w_clr) | w_set;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; busy is registered from the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 8'h00;
      r_code  <= 3'b000;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_pend_nxt != 8'h00) || w_valid_nxt;
    end
  end

`ifdef ENC_OVF_EN
  logic r_ovf;
  logic w_ovf_hit;

  assign w_ovf_hit = |(w_set & r_pend & ~w_clr);

  // Sticky overflow: a request re-arrives for a bit that is still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_hit) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign {c, a, b} = r_code;
  assign valid     = r_valid;
  assign busy      = r_busy;

endmodule
